uart_cmd_ctrl: RTL and testbench

Command-frame controller that sits behind uart_rx in the correlator's host link and drives its rx_bits configuration. Collects received words into fixed-format frames: header, address, DATA_BYTES payload, checksum. Validates each frame and issues one register-write handshake toward the correlator control registers. Flags checksum errors, inter-byte timeouts and overruns.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_frame_timeout.sv | 35 +++
 rtl/uart_cmd_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART command-frame controller.
package uart_pkg;

  localparam int ADDR_W = 8;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_CSUM  = 3'd3;
  localparam state_t ST_WRITE = 3'd4;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: down-counter reloaded on load, expires at terminal count 0.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on load, otherwise count down while enabled and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: header, address, payload, checksum -> one register write.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | hunting for the header byte, other bytes dropped silently
// ST_ADDR  | waiting for the address byte
// ST_DATA  | collecting payload bytes, MSB first
// ST_CSUM  | waiting for the checksum byte
// ST_WRITE | reg_wr held until reg_ack; incoming bytes are overruns
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         DATA_BYTES  = 4,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         WORD_BITS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [5:0]        rx_bits,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err_csum,
  output logic              err_timeout,
  output logic              err_overrun
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              err_csum_q, err_csum_d;
  logic              err_tout_q, err_tout_d;
  logic              err_ovr_q, err_ovr_d;

  logic       tmr_en, tmr_load, tmr_expire;
  logic       last_data;
  logic [7:0] csum_sum;

  assign tmr_en    = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign tmr_load  = rx_done || !tmr_en;
  assign last_data = (cnt_q == 3'(DATA_BYTES - 1));
  assign csum_sum  = acc_q + rx_data;

  uart_frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a received byte always takes priority over timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rx_done && (rx_data == HEADER)) state_d = ST_ADDR;
      ST_ADDR:  if (rx_done) state_d = ST_DATA;
                else if (tmr_expire) state_d = ST_IDLE;
      ST_DATA:  if (rx_done) begin
                  if (last_data) state_d = ST_CSUM;
                end else if (tmr_expire) state_d = ST_IDLE;
      ST_CSUM:  if (rx_done) state_d = (csum_sum == 8'h00) ? ST_WRITE : ST_IDLE;
                else if (tmr_expire) state_d = ST_IDLE;
      ST_WRITE: if (reg_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_csum_d = 1'b0;
    err_tout_d = 1'b0;
    err_ovr_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_done && (rx_data == HEADER)) begin
        acc_d   = 8'h00;
        cnt_d   = 3'd0;
        wdata_d = 32'h0;
      end
      ST_ADDR: if (rx_done) begin
        addr_d = rx_data;
        acc_d  = rx_data;
      end
      ST_DATA: if (rx_done) begin
        wdata_d = {wdata_q[23:0], rx_data};
        acc_d   = csum_sum;
        cnt_d   = cnt_q + 3'd1;
      end
      ST_CSUM: if (rx_done) err_csum_d = (csum_sum != 8'h00);
      ST_WRITE: err_ovr_d = rx_done;
      default: ;
    endcase
    if (tmr_en && tmr_expire && !rx_done) err_tout_d = 1'b1;
    wr_d   = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_csum_q <= 1'b0;
      err_tout_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      err_csum_q <= err_csum_d;
      err_tout_q <= err_tout_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  assign rx_bits     = 6'(WORD_BITS);
  assign reg_wr      = wr_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign busy        = busy_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_tout_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl with a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int         DATA_BYTES  = 4;
  localparam int         TIMEOUT_CYC = 20;
  localparam int         WORD_BITS   = 8;
  localparam logic [7:0] HDR         = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        reg_ack = 1'b0;
  logic [5:0]  rx_bits;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        busy, err_csum, err_timeout, err_overrun;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_csum = 0, n_tout = 0, n_ovr = 0;
  logic        wr_prev = 1'b0;
  logic [7:0]  addr_prev = 8'h00;
  logic [31:0] data_prev = 32'h0;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .DATA_BYTES(DATA_BYTES), .HEADER(HDR), .TIMEOUT_CYC(TIMEOUT_CYC), .WORD_BITS(WORD_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .rx_bits(rx_bits),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack),
    .busy(busy), .err_csum(err_csum), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  // Event monitor sampled 2ns after each rising edge; also checks write-hold stability.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      wr_prev = 1'b0;
    end else begin
      if (reg_wr && wr_prev) begin
        checks++;
        if (reg_addr !== addr_prev || reg_wdata !== data_prev) begin
          errors++;
          $display("FAIL hold_stable addr=%h data=%h required addr=%h data=%h",
                   reg_addr, reg_wdata, addr_prev, data_prev);
        end
      end
      if (reg_wr && !wr_prev) n_wr++;
      if (err_csum)    n_csum++;
      if (err_timeout) n_tout++;
      if (err_overrun) n_ovr++;
      wr_prev   = reg_wr;
      addr_prev = reg_addr;
      data_prev = reg_wdata;
    end
  end

  // Reference checksum: two's complement of the 8-bit sum of address and payload.
  function automatic logic [7:0] model_csum(input logic [7:0] a, input logic [31:0] d);
    int s;
    s = a;
    for (int i = 0; i < DATA_BYTES; i++) s += int'((d >> (8 * i)) & 32'hFF);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs,
                            input int maxgap);
    logic [31:0] dv;
    dv = d;
    send_byte(HDR);
    idle($urandom_range(0, maxgap));
    send_byte(a);
    for (int i = 0; i < DATA_BYTES; i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(dv[31 - 8 * i -: 8]);
    end
    idle($urandom_range(0, maxgap));
    send_byte(cs);
  endtask

  task automatic pulse_ack();
    reg_ack = 1'b1;
    @(negedge clk);
    reg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({reg_wr, busy, err_csum, err_timeout, err_overrun} !== 5'b0 || reg_addr !== 8'h00 ||
        reg_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs wr=%b busy=%b errs=%b%b%b addr=%h data=%h required all zero",
               reg_wr, busy, err_csum, err_timeout, err_overrun, reg_addr, reg_wdata);
    end
    checks++;
    if (rx_bits !== 6'(WORD_BITS)) begin
      errors++;
      $display("FAIL reset_rx_bits got=%0d required=%0d", rx_bits, WORD_BITS);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame();
    int w0;
    w0 = n_wr;
    send_frame(8'h10, 32'hDEADBEEF, model_csum(8'h10, 32'hDEADBEEF), 0);
    checks++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h10 || reg_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL valid_write wr=%b addr=%h data=%h required 1 10 deadbeef",
               reg_wr, reg_addr, reg_wdata);
    end
    idle(3);
    checks++;
    if (reg_wr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL valid_hold wr=%b busy=%b required 1 1", reg_wr, busy);
    end
    pulse_ack();
    checks++;
    if (reg_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_ack_drop wr=%b busy=%b required 0 0", reg_wr, busy);
    end
    checks++;
    if (n_wr - w0 !== 1) begin
      errors++;
      $display("FAIL valid_count writes=%0d required=1", n_wr - w0);
    end
  endtask

  task automatic test_bad_csum();
    int w0, c0;
    logic [7:0] a;
    logic [31:0] d;
    w0 = n_wr;
    c0 = n_csum;
    send_frame(8'h10, 32'hDEADBEEF, model_csum(8'h10, 32'hDEADBEEF) + 8'h01, 0);
    checks++;
    if (err_csum !== 1'b1 || reg_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_err err=%b wr=%b busy=%b required 1 0 0", err_csum, reg_wr, busy);
    end
    idle(1);
    checks++;
    if (err_csum !== 1'b0 || n_csum - c0 !== 1) begin
      errors++;
      $display("FAIL csum_pulse err=%b pulses=%0d required 0 1", err_csum, n_csum - c0);
    end
    a = 8'($urandom);
    d = $urandom;
    send_frame(a, d, model_csum(a, d), 2);
    checks++;
    if (reg_wr !== 1'b1 || reg_addr !== a || reg_wdata !== d) begin
      errors++;
      $display("FAIL csum_recover wr=%b addr=%h data=%h required 1 %h %h",
               reg_wr, reg_addr, reg_wdata, a, d);
    end
    pulse_ack();
    checks++;
    if (n_wr - w0 !== 1) begin
      errors++;
      $display("FAIL csum_writes writes=%0d required=1", n_wr - w0);
    end
  endtask

  task automatic test_garbage();
    int w0, e0;
    w0 = n_wr;
    e0 = n_csum + n_tout + n_ovr;
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(3);
    send_byte(8'h12);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL garbage_busy busy=%b required 0", busy);
    end
    send_frame(8'h3C, 32'h01234567, model_csum(8'h3C, 32'h01234567), 1);
    checks++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h3C || reg_wdata !== 32'h01234567) begin
      errors++;
      $display("FAIL garbage_write wr=%b addr=%h data=%h required 1 3c 01234567",
               reg_wr, reg_addr, reg_wdata);
    end
    pulse_ack();
    checks++;
    if (n_wr - w0 !== 1 || (n_csum + n_tout + n_ovr) - e0 !== 0) begin
      errors++;
      $display("FAIL garbage_counts writes=%0d errs=%0d required 1 0",
               n_wr - w0, (n_csum + n_tout + n_ovr) - e0);
    end
  endtask

  task automatic test_timeout();
    int first_k, t0;
    logic [31:0] d;
    t0 = n_tout;
    first_k = -1;
    send_byte(HDR);
    send_byte(8'h10);
    send_byte(8'hDE);
    for (int k = 1; k <= TIMEOUT_CYC + 5; k++) begin
      @(negedge clk);
      if (err_timeout === 1'b1 && first_k < 0) first_k = k;
    end
    checks++;
    if (first_k !== TIMEOUT_CYC) begin
      errors++;
      $display("FAIL timeout_latency got=%0d required=%0d", first_k, TIMEOUT_CYC);
    end
    checks++;
    if (busy !== 1'b0 || n_tout - t0 !== 1) begin
      errors++;
      $display("FAIL timeout_idle busy=%b pulses=%0d required 0 1", busy, n_tout - t0);
    end
    t0 = n_tout;
    send_byte(HDR);
    send_byte(8'h10);
    send_byte(8'hDE);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h55);
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_coincide err=%b busy=%b required 0 1", err_timeout, busy);
    end
    d = 32'hDE5577AA;
    send_byte(8'h77);
    send_byte(8'hAA);
    send_byte(model_csum(8'h10, d));
    checks++;
    if (reg_wr !== 1'b1 || reg_wdata !== d || n_tout - t0 !== 0) begin
      errors++;
      $display("FAIL timeout_coincide_write wr=%b data=%h touts=%0d required 1 %h 0",
               reg_wr, reg_wdata, n_tout - t0, d);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] a;
    logic [31:0] d;
    o0 = n_ovr;
    a = 8'($urandom);
    d = $urandom;
    send_frame(a, d, model_csum(a, d), 0);
    idle(5);
    send_byte(HDR);
    checks++;
    if (err_overrun !== 1'b1 || reg_wr !== 1'b1 || reg_addr !== a || reg_wdata !== d) begin
      errors++;
      $display("FAIL overrun_pulse ovr=%b wr=%b addr=%h data=%h required 1 1 %h %h",
               err_overrun, reg_wr, reg_addr, reg_wdata, a, d);
    end
    idle(44);
    checks++;
    if (reg_wr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold wr=%b required 1", reg_wr);
    end
    pulse_ack();
    checks++;
    if (reg_wr !== 1'b0 || busy !== 1'b0 || n_ovr - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_done wr=%b busy=%b pulses=%0d required 0 0 1",
               reg_wr, busy, n_ovr - o0);
    end
    send_frame(a, d, model_csum(a, d), 0);
    idle(2);
    rx_data = HDR;
    rx_done = 1'b1;
    reg_ack = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    reg_ack = 1'b0;
    checks++;
    if (err_overrun !== 1'b1 || busy !== 1'b0 || reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_with_ack ovr=%b busy=%b wr=%b required 1 0 0",
               err_overrun, busy, reg_wr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    send_byte(HDR);
    send_byte(8'h10);
    send_byte(8'hDE);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_wr, busy, err_csum, err_timeout, err_overrun} !== 5'b0 || reg_addr !== 8'h00 ||
        reg_wdata !== 32'h0 || rx_bits !== 6'(WORD_BITS)) begin
      errors++;
      $display("FAIL reset_mid_frame wr=%b busy=%b addr=%h data=%h bits=%0d required zeros and %0d",
               reg_wr, busy, reg_addr, reg_wdata, rx_bits, WORD_BITS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    d = 32'hCAFE0042;
    send_frame(8'h77, d, model_csum(8'h77, d), 1);
    checks++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h77 || reg_wdata !== d) begin
      errors++;
      $display("FAIL reset_then_write wr=%b addr=%h data=%h required 1 77 %h",
               reg_wr, reg_addr, reg_wdata, d);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_wr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write wr=%b busy=%b required 0 0", reg_wr, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int w0, c0, t0, o0, n_good, n_bad;
    logic [7:0] a, cs;
    logic [31:0] d;
    logic bad;
    w0 = n_wr; c0 = n_csum; t0 = n_tout; o0 = n_ovr;
    n_good = 0;
    n_bad = 0;
    for (int it = 0; it < 24; it++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        logic [7:0] junk;
        junk = 8'($urandom);
        if (junk == HDR) junk = 8'h00;
        send_byte(junk);
      end
      a = 8'($urandom);
      d = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      cs = model_csum(a, d);
      if (bad) cs = cs + 8'($urandom_range(1, 255));
      send_frame(a, d, cs, 10);
      checks++;
      if (bad) begin
        n_bad++;
        if (err_csum !== 1'b1 || reg_wr !== 1'b0) begin
          errors++;
          $display("FAIL rand_bad it=%0d csum_err=%b wr=%b required 1 0", it, err_csum, reg_wr);
        end
      end else begin
        n_good++;
        if (reg_wr !== 1'b1 || reg_addr !== a || reg_wdata !== d) begin
          errors++;
          $display("FAIL rand_good it=%0d wr=%b addr=%h data=%h required 1 %h %h",
                   it, reg_wr, reg_addr, reg_wdata, a, d);
        end
        idle($urandom_range(0, 4));
        pulse_ack();
      end
    end
    checks++;
    if (n_wr - w0 !== n_good || n_csum - c0 !== n_bad || n_tout - t0 !== 0 || n_ovr - o0 !== 0) begin
      errors++;
      $display("FAIL rand_counts writes=%0d csum=%0d tout=%0d ovr=%0d required %0d %0d 0 0",
               n_wr - w0, n_csum - c0, n_tout - t0, n_ovr - o0, n_good, n_bad);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_bad_csum();
    test_garbage();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
